// File: rtl/robo_pkg.sv
// Shared definitions for the robot plant model: heading encoding, FSM states,
// per-heading displacement and heading arithmetic helpers.
package robo_pkg;

  localparam logic [1:0] RUMO_N = 2'd0;
  localparam logic [1:0] RUMO_E = 2'd1;
  localparam logic [1:0] RUMO_S = 2'd2;
  localparam logic [1:0] RUMO_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVENDO = 2'd1,
    GIRANDO = 2'd2
  } estado_t;

  localparam logic signed [1:0] DX_N = 2'sb00;
  localparam logic signed [1:0] DX_E = 2'sb01;
  localparam logic signed [1:0] DX_S = 2'sb00;
  localparam logic signed [1:0] DX_W = 2'sb11;
  localparam logic signed [1:0] DY_N = 2'sb01;
  localparam logic signed [1:0] DY_E = 2'sb00;
  localparam logic signed [1:0] DY_S = 2'sb11;
  localparam logic signed [1:0] DY_W = 2'sb00;

  function automatic logic signed [1:0] dx(input logic [1:0] h);
    case (h)
      RUMO_N:  return DX_N;
      RUMO_E:  return DX_E;
      RUMO_S:  return DX_S;
      default: return DX_W;
    endcase
  endfunction

  function automatic logic signed [1:0] dy(input logic [1:0] h);
    case (h)
      RUMO_N:  return DY_N;
      RUMO_E:  return DY_E;
      RUMO_S:  return DY_S;
      default: return DY_W;
    endcase
  endfunction

  function automatic logic [1:0] gira_dir(input logic [1:0] h);
    return h + 2'd1;
  endfunction

  function automatic logic [1:0] esquerda(input logic [1:0] h);
    return h + 2'd3;
  endfunction

endpackage

// File: rtl/robo_ambiente_sensores.sv
// Combinational wall lookup: cell ahead and cell to the left of the pose,
// with out-of-bounds cells reading as wall.
module robo_ambiente_sensores
  import robo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic [XW-1:0]                  pos_x,
  input  logic [YW-1:0]                  pos_y,
  input  logic [1:0]                     rumo,
  input  logic [HEIGHT-1:0][WIDTH-1:0]   mapa,
  output logic                           head,
  output logic                           left,
  output logic                           alvo_ok,
  output logic [XW-1:0]                  alvo_x,
  output logic [YW-1:0]                  alvo_y
);

  localparam logic [XW:0] XLIM = (XW+1)'(WIDTH);
  localparam logic [YW:0] YLIM = (YW+1)'(HEIGHT);

  // One extra bit: -1 wraps to a set MSB, so negatives fail the bound test.
  function automatic logic [XW:0] col(input logic [XW-1:0] x, input logic [1:0] h);
    return {1'b0, x} + (XW+1)'(dx(h));
  endfunction

  function automatic logic [YW:0] lin(input logic [YW-1:0] y, input logic [1:0] h);
    return {1'b0, y} + (YW+1)'(dy(h));
  endfunction

  function automatic logic dentro(input logic [XW:0] c, input logic [YW:0] r);
    return !c[XW] && (c < XLIM) && !r[YW] && (r < YLIM);
  endfunction

  logic [XW:0] hx, lx;
  logic [YW:0] hy, ly;
  logic        left_ok;

  always_comb begin
    hx      = col(pos_x, rumo);
    hy      = lin(pos_y, rumo);
    lx      = col(pos_x, esquerda(rumo));
    ly      = lin(pos_y, esquerda(rumo));
    alvo_ok = dentro(hx, hy);
    left_ok = dentro(lx, ly);
    head    = !alvo_ok || mapa[hy[YW-1:0]][hx[XW-1:0]];
    left    = !left_ok || mapa[ly[YW-1:0]][lx[XW-1:0]];
    alvo_x  = hx[XW-1:0];
    alvo_y  = hy[YW-1:0];
  end

endmodule

// File: rtl/robo_ambiente.sv
// Robot plant model on a wall grid; build with ROBO_AMBIENTE_VISIT_EN to add
// the visited-cell bitmap and the cobertura counter.
module robo_ambiente
  import robo_pkg::*;
#(
  parameter int         WIDTH       = 8,
  parameter int         HEIGHT      = 8,
  parameter int         STEP_CYCLES = 4,
  parameter int         START_X     = 0,
  parameter int         START_Y     = 0,
  parameter logic [1:0] START_DIR   = 2'd0,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          avancar,
  input  logic          girar,
  input  logic          map_we,
  input  logic [XW-1:0] map_x,
  input  logic [YW-1:0] map_y,
  input  logic          map_wdata,
  output logic          head,
  output logic          left,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [1:0]    rumo,
  output logic          ocupado,
  output logic          colisao,
  output logic          erro_cmd,
  output logic [15:0]   passos,
  output logic [15:0]   cobertura
);

  localparam int CW = $clog2(STEP_CYCLES + 1);

  estado_t                     estado_q, estado_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [XW-1:0]               px_q, px_d;
  logic [YW-1:0]               py_q, py_d;
  logic [1:0]                  rumo_q, rumo_d;
  logic [HEIGHT-1:0][WIDTH-1:0] map_q, map_d;
  logic                        colisao_q, colisao_d;
  logic                        erro_q, erro_d;
  logic [15:0]                 passos_q, passos_d;
  logic                        alvo_ok;
  logic [XW-1:0]               alvo_x;
  logic [YW-1:0]               alvo_y;
`ifdef ROBO_AMBIENTE_VISIT_EN
  logic [HEIGHT-1:0][WIDTH-1:0] visit_q, visit_d;
  logic [15:0]                  cob_q, cob_d;
`endif

  // The same lookup serves the live sensors and the re-check at commit.
  robo_ambiente_sensores #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_sensores (
    .pos_x   (px_q),
    .pos_y   (py_q),
    .rumo    (rumo_q),
    .mapa    (map_q),
    .head    (head),
    .left    (left),
    .alvo_ok (alvo_ok),
    .alvo_x  (alvo_x),
    .alvo_y  (alvo_y)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= IDLE;
      cnt_q     <= '0;
      px_q      <= XW'(START_X);
      py_q      <= YW'(START_Y);
      rumo_q    <= START_DIR;
      map_q     <= '0;
      colisao_q <= 1'b0;
      erro_q    <= 1'b0;
      passos_q  <= '0;
`ifdef ROBO_AMBIENTE_VISIT_EN
      visit_q                   <= '0;
      visit_q[START_Y][START_X] <= 1'b1;
      cob_q                     <= 16'd1;
`endif
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      px_q      <= px_d;
      py_q      <= py_d;
      rumo_q    <= rumo_d;
      map_q     <= map_d;
      colisao_q <= colisao_d;
      erro_q    <= erro_d;
      passos_q  <= passos_d;
`ifdef ROBO_AMBIENTE_VISIT_EN
      visit_q   <= visit_d;
      cob_q     <= cob_d;
`endif
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    px_d      = px_q;
    py_d      = py_q;
    rumo_d    = rumo_q;
    map_d     = map_q;
    colisao_d = colisao_q;
    erro_d    = erro_q;
    passos_d  = passos_q;
`ifdef ROBO_AMBIENTE_VISIT_EN
    visit_d   = visit_q;
    cob_d     = cob_q;
`endif
    if (map_we && (int'(map_x) < WIDTH) && (int'(map_y) < HEIGHT))
      map_d[map_y][map_x] = map_wdata;
    case (estado_q)
      IDLE: begin
        if (avancar && girar) begin
          erro_d = 1'b1;
        end else if (avancar) begin
          if (head) begin
            colisao_d = 1'b1;
          end else begin
            estado_d = MOVENDO;
            cnt_d    = CW'(STEP_CYCLES - 1);
          end
        end else if (girar) begin
          estado_d = GIRANDO;
          cnt_d    = CW'(STEP_CYCLES - 1);
        end
      end
      MOVENDO: begin
        if (cnt_q == '0) begin
          estado_d = IDLE;
          // A wall written into the target during the move aborts it.
          if (alvo_ok && !head) begin
            px_d = alvo_x;
            py_d = alvo_y;
            if (passos_q != 16'hFFFF) passos_d = passos_q + 16'd1;
`ifdef ROBO_AMBIENTE_VISIT_EN
            if (!visit_q[alvo_y][alvo_x]) begin
              visit_d[alvo_y][alvo_x] = 1'b1;
              if (cob_q != 16'hFFFF) cob_d = cob_q + 16'd1;
            end
`endif
          end else begin
            colisao_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GIRANDO: begin
        if (cnt_q == '0) begin
          estado_d = IDLE;
          rumo_d   = gira_dir(rumo_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_comb begin
    ocupado  = (estado_q != IDLE);
    pos_x    = px_q;
    pos_y    = py_q;
    rumo     = rumo_q;
    colisao  = colisao_q;
    erro_cmd = erro_q;
    passos   = passos_q;
`ifdef ROBO_AMBIENTE_VISIT_EN
    cobertura = cob_q;
`else
    cobertura = 16'd0;
`endif
  end

endmodule

// File: tb/tb_robo_ambiente.sv
// Directed bench for robo_ambiente: 8x8 grid, 4-cycle steps, start (0,0) N.
module tb_robo_ambiente;

  localparam int STEP = 4;
`ifdef ROBO_AMBIENTE_VISIT_EN
  localparam logic [15:0] COB_RST  = 16'd1;
  localparam logic [15:0] COB_VISI = 16'd2;
`else
  localparam logic [15:0] COB_RST  = 16'd0;
  localparam logic [15:0] COB_VISI = 16'd0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        avancar, girar, map_we, map_wdata;
  logic [2:0]  map_x, map_y;
  logic        head, left, ocupado, colisao, erro_cmd;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  rumo;
  logic [15:0] passos, cobertura;

  int checks = 0;
  int errors = 0;

  robo_ambiente #(
    .WIDTH(8), .HEIGHT(8), .STEP_CYCLES(STEP),
    .START_X(0), .START_Y(0), .START_DIR(2'd0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .avancar   (avancar),
    .girar     (girar),
    .map_we    (map_we),
    .map_x     (map_x),
    .map_y     (map_y),
    .map_wdata (map_wdata),
    .head      (head),
    .left      (left),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .rumo      (rumo),
    .ocupado   (ocupado),
    .colisao   (colisao),
    .erro_cmd  (erro_cmd),
    .passos    (passos),
    .cobertura (cobertura)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pose(input string tag, input int ex, input int ey, input int er);
    chk({tag, "_x"}, 32'(pos_x), ex);
    chk({tag, "_y"}, 32'(pos_y), ey);
    chk({tag, "_rumo"}, 32'(rumo), er);
  endtask

  // Issue one command for a single edge, then let the operation finish.
  task automatic do_cmd(input logic av, input logic gi);
    avancar = av;
    girar   = gi;
    tick();
    avancar = 1'b0;
    girar   = 1'b0;
    repeat (STEP) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; avancar = 1'b0; girar = 1'b0;
    map_we = 1'b0; map_x = '0; map_y = '0; map_wdata = 1'b0;
    #3;
    chk_pose("rst", 0, 0, 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_head", 32'(head), 0);
    chk("rst_left", 32'(left), 1);
    chk("rst_passos", 32'(passos), 0);
    chk("rst_colisao", 32'(colisao), 0);
    chk("rst_erro", 32'(erro_cmd), 0);
    chk("rst_cobertura", 32'(cobertura), 32'(COB_RST));
    @(negedge clock);
    reset = 1'b0;

    // Single move north; a girar pulse while busy must be ignored.
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    chk("mv_ocupado_acc", 32'(ocupado), 1);
    chk("mv_y_acc", 32'(pos_y), 0);
    for (int j = 1; j <= STEP; j++) begin
      tick();
      if (j < STEP) begin
        chk("mv_ocupado_mid", 32'(ocupado), 1);
        chk("mv_y_mid", 32'(pos_y), 0);
      end else begin
        chk("mv_ocupado_end", 32'(ocupado), 0);
        chk("mv_y_end", 32'(pos_y), 1);
      end
      if (j == 2) girar = 1'b1;
      if (j == 3) girar = 1'b0;
    end
    chk("mv_passos", 32'(passos), 1);
    chk("mv_busy_girar", 32'(rumo), 0);

    // Travel to (7,3) facing east.
    do_cmd(1'b1, 1'b0);
    do_cmd(1'b1, 1'b0);
    chk_pose("at03", 0, 3, 0);
    chk("at03_left", 32'(left), 1);
    do_cmd(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) do_cmd(1'b1, 1'b0);
    chk_pose("at73", 7, 3, 1);
    chk("at73_passos", 32'(passos), 10);
    chk("at73_head", 32'(head), 1);
    chk("at73_left", 32'(left), 0);

    // Blocked advance at the east border.
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    chk("blk_colisao", 32'(colisao), 1);
    chk("blk_ocupado", 32'(ocupado), 0);
    chk_pose("blk", 7, 3, 1);
    chk("blk_passos", 32'(passos), 10);

    // Turn timing, then wrap 3 -> 0.
    girar = 1'b1;
    tick();
    girar = 1'b0;
    chk("turn_ocupado", 32'(ocupado), 1);
    repeat (STEP - 1) tick();
    chk("turn_rumo_mid", 32'(rumo), 1);
    tick();
    chk("turn_rumo_end", 32'(rumo), 2);
    chk("turn_ocupado_end", 32'(ocupado), 0);
    do_cmd(1'b0, 1'b1);
    chk("turn_rumo3", 32'(rumo), 3);
    do_cmd(1'b0, 1'b1);
    chk("turn_wrap", 32'(rumo), 0);

    // Conflicting commands.
    chk("erro_before", 32'(erro_cmd), 0);
    avancar = 1'b1;
    girar   = 1'b1;
    tick();
    avancar = 1'b0;
    girar   = 1'b0;
    chk("erro_set", 32'(erro_cmd), 1);
    chk("erro_ocupado", 32'(ocupado), 0);
    chk_pose("erro", 7, 3, 0);
    tick();
    chk("erro_sticky", 32'(erro_cmd), 1);

    // Move aborted by a wall written into its target.
    pulse_reset();
    chk("rst2_colisao", 32'(colisao), 0);
    chk("rst2_erro", 32'(erro_cmd), 0);
    chk("rst2_passos", 32'(passos), 0);
    chk_pose("rst2", 0, 0, 0);
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    tick();
    map_we = 1'b1; map_x = 3'd0; map_y = 3'd1; map_wdata = 1'b1;
    tick();
    map_we = 1'b0;
    chk("abt_head", 32'(head), 1);
    chk("abt_ocupado_mid", 32'(ocupado), 1);
    tick();
    tick();
    chk("abt_ocupado", 32'(ocupado), 0);
    chk_pose("abt", 0, 0, 0);
    chk("abt_colisao", 32'(colisao), 1);
    chk("abt_passos", 32'(passos), 0);
    do_cmd(1'b0, 1'b1);
    chk("abt_e_head", 32'(head), 0);
    chk("abt_e_left", 32'(left), 1);

    // Reset clears the map; then N, S, N.
    pulse_reset();
    chk("rst3_head", 32'(head), 0);
    do_cmd(1'b1, 1'b0);
    do_cmd(1'b0, 1'b1);
    do_cmd(1'b0, 1'b1);
    do_cmd(1'b1, 1'b0);
    do_cmd(1'b0, 1'b1);
    do_cmd(1'b0, 1'b1);
    do_cmd(1'b1, 1'b0);
    chk_pose("nsn", 0, 1, 0);
    chk("nsn_passos", 32'(passos), 3);
    chk("nsn_cobertura", 32'(cobertura), 32'(COB_VISI));

    // Asynchronous reset in the middle of a move.
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    tick();
    chk("mid_ocupado", 32'(ocupado), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ocupado", 32'(ocupado), 0);
    chk_pose("mid_rst", 0, 0, 0);
    chk("mid_rst_passos", 32'(passos), 0);
    chk("mid_rst_cobertura", 32'(cobertura), 32'(COB_RST));
    #2;
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
